// File: rtl/sram_like_arbiter_if.sv
// ============================================================================
// sram_like_arbiter_if : bundle of the inst, data and shared memory SRAM-like
//                        ports arbitrated by sram_like_arbiter.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [1:0]        inst_size;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  logic              arb_busy;

  // Environment side: pipeline requesters plus the memory responder.
  modport master (
    output inst_req, inst_addr, inst_size,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  arb_busy
  );

  modport slave (
    input  inst_req, inst_addr, inst_size,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output arb_busy
  );
endinterface

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// sram_like_arbiter : shares one SRAM-like port between inst and data
//                     requesters, one transaction outstanding, data priority.
// Optional macro ARB_STARVE_GUARD_EN : grants inst after STARVE_MAX data wins.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sram_like_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_data_q, grant_data_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Once data has won STARVE_MAX times in a row over a waiting inst, inst wins.
  assign pick_data = bus.data_req &&
                     !(bus.inst_req && (starve_q == CNT_W'(STARVE_MAX)));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!bus.inst_req) begin
        starve_d = '0;
      end else if (pick_data) begin
        starve_d = starve_q + CNT_W'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign pick_data = bus.data_req;
`endif

  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.inst_req || bus.data_req) begin
          state_d      = ADDR;
          grant_data_d = pick_data;
          if (pick_data) begin
            wr_d    = bus.data_wr;
            size_d  = bus.data_size;
            addr_d  = bus.data_addr;
            wstrb_d = bus.data_wstrb;
            wdata_d = bus.data_wdata;
          end else begin
            wr_d    = 1'b0;
            size_d  = bus.inst_size;
            addr_d  = bus.inst_addr;
            wstrb_d = 4'h0;
            wdata_d = '0;
          end
        end
      end
      ADDR: begin
        if (bus.mem_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.mem_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_data_q <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wstrb_q      <= 4'h0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
    end
  end

  // Handshake pulses pass through combinationally so zero-wait memory costs no cycle.
  assign bus.mem_req      = (state_q == ADDR);
  assign bus.mem_wr       = wr_q;
  assign bus.mem_size     = size_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wstrb    = wstrb_q;
  assign bus.mem_wdata    = wdata_q;

  assign bus.inst_addr_ok = (state_q == ADDR) && bus.mem_addr_ok && !grant_data_q;
  assign bus.data_addr_ok = (state_q == ADDR) && bus.mem_addr_ok &&  grant_data_q;
  assign bus.inst_data_ok = (state_q == DATA) && bus.mem_data_ok && !grant_data_q;
  assign bus.data_data_ok = (state_q == DATA) && bus.mem_data_ok &&  grant_data_q;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  assign bus.arb_busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// tb_sram_like_arbiter : directed self-checking bench for sram_like_arbiter.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_like_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_req"},  bus.mem_req, 1'b0);
    chk({tag, ".i_aok"},    bus.inst_addr_ok, 1'b0);
    chk({tag, ".d_aok"},    bus.data_addr_ok, 1'b0);
    chk({tag, ".i_dok"},    bus.inst_data_ok, 1'b0);
    chk({tag, ".d_dok"},    bus.data_data_ok, 1'b0);
    chk({tag, ".busy"},     bus.arb_busy, 1'b0);
  endtask

  logic exp_d;

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn          = 1'b0;
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.inst_size   = 2'd0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd0;
    bus.data_addr   = '0;
    bus.data_wstrb  = 4'h0;
    bus.data_wdata  = '0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;

    // Reset state
    tick(); tick();
    #1;
    chk_quiet("rst");
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.mem_wr",   bus.mem_wr, 1'b0);
    chk("rst.i_rdata",  bus.inst_rdata, 32'h0);
    resetn = 1'b1;

    // Single inst read, zero-wait memory
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0000;
    bus.inst_size = 2'd2;
    #1;
    chk("t1.n_busy", bus.arb_busy, 1'b0);
    chk("t1.n_req",  bus.mem_req, 1'b0);
    tick();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t1.mem_req",  bus.mem_req, 1'b1);
    chk("t1.mem_addr", bus.mem_addr, 32'h1C00_0000);
    chk("t1.mem_size", bus.mem_size, 2'd2);
    chk("t1.mem_wr",   bus.mem_wr, 1'b0);
    chk("t1.mem_strb", bus.mem_wstrb, 4'h0);
    chk("t1.i_aok",    bus.inst_addr_ok, 1'b1);
    chk("t1.d_aok",    bus.data_addr_ok, 1'b0);
    tick();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h0280_0404;
    #1;
    chk("t1.req_low", bus.mem_req, 1'b0);
    chk("t1.i_dok",   bus.inst_data_ok, 1'b1);
    chk("t1.i_rdata", bus.inst_rdata, 32'h0280_0404);
    chk("t1.d_dok",   bus.data_data_ok, 1'b0);
    chk("t1.busy",    bus.arb_busy, 1'b1);
    tick();
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
    #1;
    chk_quiet("t1.end");

    // Data write with 3 stalled addr_ok cycles
    tick();
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd2;
    bus.data_addr  = 32'h0000_1000;
    bus.data_wstrb = 4'hF;
    bus.data_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t2.n_busy", bus.arb_busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mem_addr_ok = (i == 3);
      #1;
      chk("t2.mem_req",  bus.mem_req, 1'b1);
      chk("t2.mem_wr",   bus.mem_wr, 1'b1);
      chk("t2.mem_addr", bus.mem_addr, 32'h0000_1000);
      chk("t2.mem_strb", bus.mem_wstrb, 4'hF);
      chk("t2.mem_wdat", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("t2.d_aok",    bus.data_addr_ok, (i == 3));
      chk("t2.i_aok",    bus.inst_addr_ok, 1'b0);
      chk("t2.busy",     bus.arb_busy, 1'b1);
    end
    tick();
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.mem_addr_ok = 1'b0;
    #1;
    chk("t2.wait_req", bus.mem_req, 1'b0);
    chk("t2.wait_dok", bus.data_data_ok, 1'b0);
    chk("t2.wait_bsy", bus.arb_busy, 1'b1);
    tick();
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t2.d_dok", bus.data_data_ok, 1'b1);
    chk("t2.i_dok", bus.inst_data_ok, 1'b0);
    chk("t2.d_aok", bus.data_addr_ok, 1'b0);
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    chk_quiet("t2.end");

    // Simultaneous requests: data first, inst on the next IDLE
    tick();
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h1C00_0010;
    bus.data_req   = 1'b1;
    bus.data_addr  = 32'h0000_2000;
    bus.data_wstrb = 4'h0;
    #1;
    chk("t3.n_busy", bus.arb_busy, 1'b0);
    tick();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t3.d_aok",  bus.data_addr_ok, 1'b1);
    chk("t3.i_aok",  bus.inst_addr_ok, 1'b0);
    chk("t3.addr_d", bus.mem_addr, 32'h0000_2000);
    tick();
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h1234_5678;
    #1;
    chk("t3.d_dok",   bus.data_data_ok, 1'b1);
    chk("t3.d_rdata", bus.data_rdata, 32'h1234_5678);
    chk("t3.i_dok",   bus.inst_data_ok, 1'b0);
    chk("t3.i_aok2",  bus.inst_addr_ok, 1'b0);
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    chk("t3.idle_busy", bus.arb_busy, 1'b0);
    chk("t3.idle_req",  bus.mem_req, 1'b0);
    tick();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t3.i_aok",  bus.inst_addr_ok, 1'b1);
    chk("t3.d_aok2", bus.data_addr_ok, 1'b0);
    chk("t3.addr_i", bus.mem_addr, 32'h1C00_0010);
    tick();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t3.i_dok",  bus.inst_data_ok, 1'b1);
    chk("t3.d_dok2", bus.data_data_ok, 1'b0);
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    chk_quiet("t3.end");

    // Both held for 12 back-to-back transactions
    tick();
    bus.inst_req    = 1'b1;
    bus.data_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    bus.mem_data_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_d = ((i % 5) != 4);
`else
      exp_d = 1'b1;
`endif
      #1;
      chk("t4.idle_busy", bus.arb_busy, 1'b0);
      tick();
      #1;
      chk("t4.d_aok", bus.data_addr_ok, exp_d);
      chk("t4.i_aok", bus.inst_addr_ok, !exp_d);
      chk("t4.addr",  bus.mem_addr, exp_d ? 32'h0000_2000 : 32'h1C00_0010);
      tick();
      #1;
      chk("t4.d_dok", bus.data_data_ok, exp_d);
      chk("t4.i_dok", bus.inst_data_ok, !exp_d);
      tick();
    end
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    #1;
    chk_quiet("t4.end");

    // Reset during DATA with inst_req held
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0020;
    tick();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t5.i_aok", bus.inst_addr_ok, 1'b1);
    tick();
    bus.mem_addr_ok = 1'b0;
    #1;
    chk("t5.data_busy", bus.arb_busy, 1'b1);
    resetn          = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = '0;
    #1;
    chk_quiet("t5.rst0");
    chk("t5.rst_addr", bus.mem_addr, 32'h0);
    tick();
    #1;
    chk_quiet("t5.rst1");
    tick();
    resetn          = 1'b1;
    bus.mem_data_ok = 1'b0;
    #1;
    chk_quiet("t5.rel");
    tick();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t5.mem_req", bus.mem_req, 1'b1);
    chk("t5.addr",    bus.mem_addr, 32'h1C00_0020);
    chk("t5.i_aok2",  bus.inst_addr_ok, 1'b1);
    tick();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t5.i_dok", bus.inst_data_ok, 1'b1);
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    chk_quiet("t5.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
